// File: rtl/spram8_128k_bank.sv
// Byte-wide 128 KiB single-port synchronous RAM built from four 16Kx16 banks.
// Optional macro SPRAM8_WR_BYPASS_EN: write cycles drive vi onto vo (write-through).
module spram8_128k_bank #(
   parameter int ASZ   = 17,
   parameter int DSZ   = 8,
   parameter int BANKS = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [ASZ-1:0] ai,
   input  logic [DSZ-1:0] vi,
   input  logic           we,
   output logic [DSZ-1:0] vo
);
   localparam int BSZ   = $clog2(BANKS);
   localparam int WSZ   = ASZ - 1 - BSZ;
   localparam int DEPTH = 1 << WSZ;

   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_BYP} src_t;

   logic [BSZ-1:0] w_bank;
   logic [WSZ-1:0] w_word;
   logic           w_lane;

   assign w_bank = ai[ASZ-1 -: BSZ];
   assign w_word = ai[WSZ:1];
   assign w_lane = ai[0];

   logic [BANKS-1:0][2*DSZ-1:0] w_q;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [2*DSZ-1:0] r_mem [DEPTH];
      logic [2*DSZ-1:0] r_q;

      // NOTE: the array and its output register carry no reset so they map onto block RAM;
      // reset only gates the write strobe.
      always_ff @(posedge clk) begin
         if (!rst) begin
            if (we && (w_bank == BSZ'(b))) begin
               if (w_lane) r_mem[w_word][2*DSZ-1:DSZ] <= vi;
               else        r_mem[w_word][DSZ-1:0]     <= vi;
            end else if (!we) begin
               r_q <= r_mem[w_word];
            end
         end
      end

      assign w_q[b] = r_q;
   end

   src_t           r_src;
   logic [BSZ-1:0] r_bank;
   logic           r_lane;
`ifdef SPRAM8_WR_BYPASS_EN
   logic [DSZ-1:0] r_byp;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_src  <= SRC_ZERO;
         r_bank <= '0;
         r_lane <= 1'b0;
`ifdef SPRAM8_WR_BYPASS_EN
         r_byp  <= '0;
`endif
      end else if (!we) begin
         r_src  <= SRC_RAM;
         r_bank <= w_bank;
         r_lane <= w_lane;
      end
`ifdef SPRAM8_WR_BYPASS_EN
      else begin
         r_src <= SRC_BYP;
         r_byp <= vi;
      end
`endif
   end

   logic [2*DSZ-1:0] w_rd_word;
   assign w_rd_word = w_q[r_bank];

   // NOTE: vo gets a default before the case so no latch is inferred.
   always_comb begin
      vo = '0;
      case (r_src)
         SRC_RAM: vo = r_lane ? w_rd_word[2*DSZ-1:DSZ] : w_rd_word[DSZ-1:0];
`ifdef SPRAM8_WR_BYPASS_EN
         SRC_BYP: vo = r_byp;
`endif
         default: vo = '0;
      endcase
   end
endmodule

// File: tb/tb_spram8_128k_bank.sv
// Self-checking bench for spram8_128k_bank: directed scenarios plus random traffic
// checked against a byte-addressed associative-array model.
module tb_spram8_128k_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] ai;
   logic [7:0]  vi;
   logic        we;
   logic [7:0]  vo;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] model [int];
   logic [7:0] exp_vo;
   bit         exp_known;

   spram8_128k_bank dut (
      .clk (clk),
      .rst (rst),
      .ai  (ai),
      .vi  (vi),
      .we  (we),
      .vo  (vo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // One bus cycle; the expected vo is derived from the byte-level behaviour.
   task automatic op(input string tag, input bit r, input bit w, input logic [31:0] addr,
                     input logic [7:0] d);
      int a;
      a = int'(addr & 32'h1FFFF);
      @(negedge clk);
      rst = r;
      we  = w;
      ai  = addr[16:0];
      vi  = d;
      @(posedge clk);
      #1;
      if (r) begin
         exp_vo    = 8'h00;
         exp_known = 1'b1;
      end else if (w) begin
         model[a] = d;
`ifdef SPRAM8_WR_BYPASS_EN
         exp_vo    = d;
         exp_known = 1'b1;
`endif
      end else if (model.exists(a)) begin
         exp_vo    = model[a];
         exp_known = 1'b1;
      end else begin
         exp_known = 1'b0;
      end
      if (exp_known) check(tag, vo, exp_vo);
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  d;
      rst = 1'b1; we = 1'b0; ai = '0; vi = '0;
      exp_known = 1'b0;

      op("reset0", 1, 0, 0, 8'h00);
      op("reset1", 1, 1, 32'h00005, 8'h77);

      for (int i = 0; i <= 16; i++) op("ord_wr", 0, 1, i, 8'(i));
      for (int i = 0; i <= 20; i++) op("ord_rd", 0, 0, i, 8'h00);

      for (int i = 0; i <= 16; i++) begin
         a = (32'd1 << i) | (i & 3);
         d = (i < 8) ? 8'(1 << i) : 8'(8'hFF >> (i - 8));
         op("rng_wr", 0, 1, a, d);
      end
      for (int i = 0; i <= 16; i++) op("rng_rd", 0, 0, (32'd1 << i) | (i & 3), 8'h00);
      op("alias_wr", 0, 1, 32'h20000, 8'h9C);
      op("alias_rd", 0, 0, 32'h00000, 8'h00);

      for (int i = 0; i <= 16; i++) op("hi_wr", 0, 1, 32'h1FFFF - i, 8'(i));
      for (int i = 0; i <= 16; i++) op("hi_rd", 0, 0, 32'h1FFFF - i, 8'h00);

      op("iso_wr", 0, 1, 32'h00000, 8'hAA);
      op("iso_wr", 0, 1, 32'h00001, 8'h55);
      op("iso_wr", 0, 1, 32'h08000, 8'h11);
      op("iso_wr", 0, 1, 32'h18001, 8'h22);
      op("iso_rd", 0, 0, 32'h00000, 8'h00);
      op("iso_rd", 0, 0, 32'h08000, 8'h00);
      op("iso_rd", 0, 0, 32'h00001, 8'h00);
      op("iso_rd", 0, 0, 32'h18001, 8'h00);

      op("rst_wr",  0, 1, 32'h00100, 8'h5A);
      op("rst_mid", 1, 1, 32'h00100, 8'hFF);
      op("rst_rd",  0, 0, 32'h00100, 8'h00);

      op("wt_init", 0, 1, 32'h00010, 8'h33);
      op("wt_rd",   0, 0, 32'h00010, 8'h00);
      op("wt_wr",   0, 1, 32'h00010, 8'hC3);
      check("wt_hold", vo,
`ifdef SPRAM8_WR_BYPASS_EN
            8'hC3
`else
            8'h33
`endif
      );
      op("wt_rd2",  0, 0, 32'h00010, 8'h00);

      for (int n = 0; n < 3000; n++) begin
         a = ($urandom & 32'h1801F) | ($urandom_range(0, 1) ? 32'h07FE0 : 32'h0);
         op("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), a,
            8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
